rib_rr_arbiter: RTL and testbench
=================================

Name: rib_rr_arbiter

Overview:
- Round-robin bus arbiter for the shared RIB slave fabric of the dual-core tinyriscv SoC.
- Masters are core0 ex, core0 pc, jtag0, core1 ex, core1 pc and jtag1.
- Grants bus ownership to one master at a time, using a registered one-hot grant and a tenure quantum.
- Supports a lock request for multi-cycle atomic sequences, with a timeout that forces release.
- Produces per-master hold flags that stall every requester which has not been granted.

Parameters:
- MASTERS, 6, number of requesting masters (2..8).
- QUANTUM, 8, cycles a grant may be held while another master is waiting and lock is not asserted.
- LOCK_MAX, 64, maximum cycles a locked grant may persist before forced release.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-low.
- req_i  input  MASTERS  per-master bus request.
- lock_i  input  MASTERS  per-master lock. Only meaningful from the current owner.
- grant_o  output  MASTERS  registered one-hot grant.
- grant_idx_o  output  3  binary index of the owner. Valid only when grant_valid_o=1.
- grant_valid_o  output  1  a grant is active.
- hold_o  output  MASTERS  req_i & ~grant_o. Combinational; stalls non-owners.
- lock_timeout_o  output  1  one-cycle pulse when a lock is forcibly broken.

Behaviour:
- Reset values:
  - grant_o=0, grant_idx_o=0, grant_valid_o=0, lock_timeout_o=0.
  - last-owner pointer = MASTERS-1, so master 0 has highest priority first.
  - tenure counter = 0, lock counter = 0, state IDLE.
  - Reset dominates any in-flight grant and takes effect on the next edge.
- Clocking and latency:
  - All state and outputs except hold_o update on the rising clk edge.
  - Grant latency is one cycle: req_i sampled at edge t gives grant_o at t+1.
  - hold_o=req_i & ~grant_o at all times. While a request is pending and not yet granted, its hold is 1.
- Round-robin pick: search upward from (last+1) mod MASTERS, wrapping, and take the first requester with req_i=1.
- State IDLE:
  - No requesters: stay IDLE.
  - Otherwise: grant the pick, set last=pick, clear both counters, go to OWNED.
- State OWNED (owner o):
  - req_i[o]=0: release. If another requester exists, grant the next pick on the same edge with no bubble. Otherwise return to IDLE with grant_o=0.
  - req_i[o]=1, lock_i[o]=1, lock counter < LOCK_MAX-1: keep the grant, increment the lock counter, ignore the quantum.
  - req_i[o]=1, lock_i[o]=1, lock counter = LOCK_MAX-1: pulse lock_timeout_o and rotate to the next pick excluding o. If no other requester exists, re-grant o with the counters cleared.
  - req_i[o]=1, lock_i[o]=0: clear the lock counter and increment tenure. If tenure reaches QUANTUM-1 and another master requests, rotate to the next pick excluding o and clear tenure. If no other master requests, tenure saturates and o keeps the grant.
- Counters:
  - Tenure and lock counters are sized by $clog2 of their limit and saturate; they never wrap.
  - Lock asserted by a non-owner is ignored.
- Simultaneous events: owner release and new requests on the same edge are resolved by one pick from last+1. The released owner is eligible only after all others.
- Invariants:
  - grant_o is always one-hot or zero.
  - grant_idx_o matches the grant_o bit position.
  - grant_valid_o = |grant_o.

Test Plan:
- Reset then req_i=6'b000001 → grant_o=000001 after exactly 1 edge; hold_o=0. With rst=0 asserted mid-grant → grant_o=0 and state IDLE on the next edge.
- req_i=6'b001011 held continuously, owner never dropping, QUANTUM=8 → grants rotate 0→1→3→0, each held exactly 8 cycles, with no idle bubble between grants.
- Master 2 owner drops req on the same edge masters 2 and 5 request (2 re-requests) → grant goes to 5; master 2 is regranted only after 5 releases.
- Master 3 holds lock_i[3]=1 with masters 0 and 4 requesting → grant stays on 3 for 64 cycles, then lock_timeout_o pulses for 1 cycle and the grant moves to 4.
- Single requester 1 with lock, LOCK_MAX reached and no other requester → lock_timeout_o pulses and 1 keeps grant_o=000010 with counters cleared.
- Random req_i/lock_i for 10k cycles → grant_o one-hot or zero every cycle; hold_o == req_i & ~grant_o; no requester waits longer than (MASTERS-1)*LOCK_MAX+1 cycles.

Source files
------------

// File: rtl/rib_rr_arbiter_if.sv
// RIB arbiter bundle: master requests/locks in, one-hot grant and stalls out.
// The arbiter binds the slave modport; requesters bind the master modport.
interface rib_rr_arbiter_if #(
    parameter int MASTERS = 6
);
    logic [MASTERS-1:0] req_i;
    logic [MASTERS-1:0] lock_i;
    logic [MASTERS-1:0] grant_o;
    logic [2:0]         grant_idx_o;
    logic               grant_valid_o;
    logic [MASTERS-1:0] hold_o;
    logic               lock_timeout_o;

    modport master (
        output req_i, lock_i,
        input  grant_o, grant_idx_o, grant_valid_o,
        input  hold_o, lock_timeout_o
    );

    modport slave (
        input  req_i, lock_i,
        output grant_o, grant_idx_o, grant_valid_o,
        output hold_o, lock_timeout_o
    );
endinterface

// File: rtl/rib_rr_arbiter.sv
// Round-robin RIB bus arbiter with tenure quantum and lock timeout.
// Registered one-hot grant; combinational hold stalls every non-owner.
module rib_rr_arbiter #(
    parameter int MASTERS  = 6,
    parameter int QUANTUM  = 8,
    parameter int LOCK_MAX = 64
) (
    input logic          clk,
    input logic          rst,
    rib_rr_arbiter_if.slave bus
);
    localparam int TW = (QUANTUM > 2) ? $clog2(QUANTUM) : 1;
    localparam int LW = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
    localparam logic [TW-1:0] TEN_MAX = TW'(QUANTUM - 1);
    localparam logic [LW-1:0] LK_MAX  = LW'(LOCK_MAX - 1);
    localparam logic [2:0]    LAST_RST = 3'(MASTERS - 1);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t             state, state_n;
    logic [MASTERS-1:0] grant, grant_n;
    logic [2:0]         idx, idx_n;
    logic [2:0]         last, last_n;
    logic [TW-1:0]      ten, ten_n;
    logic [LW-1:0]      lk, lk_n;
    logic               to, to_n;

    logic [3:0] pa, po;
    logic       take;
    logic [2:0] take_idx;

    // {found, index}: first requester strictly after 'from', wrapping.
    function automatic logic [3:0] pick(
        input logic [MASTERS-1:0] r,
        input logic [2:0]         from
    );
        logic [3:0] res;
        logic [2:0] j;
        res = '0;
        for (int i = MASTERS; i >= 1; i--) begin
            j = 3'((int'(from) + i) % MASTERS);
            if (r[j]) res = {1'b1, j};
        end
        return res;
    endfunction

    assign pa = pick(bus.req_i, last);
    assign po = pick(bus.req_i & ~grant, last);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            grant <= '0;
            idx   <= '0;
            last  <= LAST_RST;
            ten   <= '0;
            lk    <= '0;
            to    <= 1'b0;
        end else begin
            state <= state_n;
            grant <= grant_n;
            idx   <= idx_n;
            last  <= last_n;
            ten   <= ten_n;
            lk    <= lk_n;
            to    <= to_n;
        end
    end

    always_comb begin
        state_n  = state;
        grant_n  = grant;
        idx_n    = idx;
        last_n   = last;
        ten_n    = ten;
        lk_n     = lk;
        to_n     = 1'b0;
        take     = 1'b0;
        take_idx = '0;
        unique case (state)
            IDLE: begin
                if (pa[3]) begin
                    take     = 1'b1;
                    take_idx = pa[2:0];
                end
            end
            OWNED: begin
                if (!bus.req_i[idx]) begin
                    if (pa[3]) begin
                        take     = 1'b1;
                        take_idx = pa[2:0];
                    end else begin
                        state_n = IDLE;
                        grant_n = '0;
                        ten_n   = '0;
                        lk_n    = '0;
                    end
                end else if (bus.lock_i[idx]) begin
                    if (lk != LK_MAX) begin
                        lk_n = lk + 1'b1;
                    end else begin
                        // Forced release; a lone owner is simply re-granted.
                        to_n     = 1'b1;
                        take     = 1'b1;
                        take_idx = po[3] ? po[2:0] : idx;
                    end
                end else begin
                    lk_n = '0;
                    if (ten != TEN_MAX) begin
                        ten_n = ten + 1'b1;
                    end else if (po[3]) begin
                        take     = 1'b1;
                        take_idx = po[2:0];
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (take) begin
            state_n = OWNED;
            idx_n   = take_idx;
            last_n  = take_idx;
            ten_n   = '0;
            lk_n    = '0;
            for (int i = 0; i < MASTERS; i++)
                grant_n[i] = (take_idx == 3'(i));
        end
    end

    assign bus.grant_o        = grant;
    assign bus.grant_idx_o    = idx;
    assign bus.grant_valid_o  = |grant;
    assign bus.hold_o         = bus.req_i & ~grant;
    assign bus.lock_timeout_o = to;
endmodule

// File: tb/tb_rib_rr_arbiter.sv
// Self-checking bench for rib_rr_arbiter: directed scenarios plus
// randomized traffic against a behavioural round-robin model.
module tb_rib_rr_arbiter;
    localparam int M  = 6;
    localparam int QN = 8;
    localparam int LM = 64;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    rib_rr_arbiter_if #(.MASTERS(M)) bus ();

    rib_rr_arbiter #(
        .MASTERS(M), .QUANTUM(QN), .LOCK_MAX(LM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: who owns the bus, whom we granted last, and how long.
    int m_owner;
    int m_last;
    int m_ten;
    int m_lk;
    bit m_to;

    function automatic int rr(input bit [M-1:0] r, input int from, input int excl);
        for (int i = 1; i <= M; i++) begin
            int c;
            c = (from + i) % M;
            if (r[c] && c != excl) return c;
        end
        return -1;
    endfunction

    function automatic void m_grant(input int p);
        m_owner = p;
        m_last  = p;
        m_ten   = 0;
        m_lk    = 0;
    endfunction

    function automatic void model_step(input bit rn, input bit [M-1:0] r, input bit [M-1:0] l);
        int p;
        m_to = 0;
        if (!rn) begin
            m_owner = -1;
            m_last  = M - 1;
            m_ten   = 0;
            m_lk    = 0;
            return;
        end
        if (m_owner < 0) begin
            p = rr(r, m_last, -1);
            if (p >= 0) m_grant(p);
        end else if (!r[m_owner]) begin
            p = rr(r, m_last, -1);
            if (p >= 0) m_grant(p);
            else m_owner = -1;
        end else if (l[m_owner]) begin
            if (m_lk < LM - 1) m_lk++;
            else begin
                m_to = 1;
                p = rr(r, m_last, m_owner);
                m_grant(p >= 0 ? p : m_owner);
            end
        end else begin
            m_lk = 0;
            if (m_ten < QN - 1) m_ten++;
            else begin
                p = rr(r, m_last, m_owner);
                if (p >= 0) m_grant(p);
            end
        end
    endfunction

    function automatic logic [M-1:0] m_grant_vec();
        logic [M-1:0] v;
        v = '0;
        if (m_owner >= 0) v[m_owner] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step(rst, bus.req_i, bus.lock_i);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.req_i  = '0;
        bus.lock_i = '0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.req_i  = '0;
        bus.lock_i = '0;
        tick();
        tick();
        checks++;
        if (bus.grant_o !== '0) begin
            failures++;
            $display("FAIL reset_grant got=%b exp=0", bus.grant_o);
        end
        checks++;
        if (bus.grant_valid_o !== 1'b0 || bus.grant_idx_o !== 3'd0) begin
            failures++;
            $display("FAIL reset_valid_idx got=%b/%0d exp=0/0", bus.grant_valid_o, bus.grant_idx_o);
        end
        checks++;
        if (bus.lock_timeout_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_timeout got=%b exp=0", bus.lock_timeout_o);
        end
        rst = 1'b1;
        bus.req_i = 6'b000001;
        tick();
        checks++;
        if (bus.grant_o !== 6'b000001 || bus.hold_o !== 6'b0) begin
            failures++;
            $display("FAIL first_grant got=%b hold=%b exp=000001 hold=000000", bus.grant_o, bus.hold_o);
        end
        checks++;
        if (bus.grant_valid_o !== 1'b1 || bus.grant_idx_o !== 3'd0) begin
            failures++;
            $display("FAIL first_valid_idx got=%b/%0d exp=1/0", bus.grant_valid_o, bus.grant_idx_o);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (bus.grant_o !== '0 || bus.grant_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_midgrant got=%b exp=000000", bus.grant_o);
        end
        checks++;
        if (bus.hold_o !== 6'b000001) begin
            failures++;
            $display("FAIL reset_hold got=%b exp=000001", bus.hold_o);
        end
        rst = 1'b1;
        bus.req_i = 6'b000010;
        tick();
        checks++;
        if (bus.grant_o !== 6'b000010 || bus.grant_idx_o !== 3'd1) begin
            failures++;
            $display("FAIL post_reset_grant got=%b/%0d exp=000010/1", bus.grant_o, bus.grant_idx_o);
        end
    endtask

    task automatic test_quantum();
        int seq[4];
        logic [M-1:0] exp;
        seq = '{0, 1, 3, 0};
        do_reset();
        bus.req_i = 6'b001011;
        for (int s = 0; s < 4; s++) begin
            exp = '0;
            exp[seq[s]] = 1'b1;
            for (int c = 0; c < QN; c++) begin
                tick();
                checks++;
                if (bus.grant_o !== exp) begin
                    failures++;
                    $display("FAIL quantum_rot slot=%0d cyc=%0d got=%b exp=%b", s, c, bus.grant_o, exp);
                end
            end
        end
    endtask

    task automatic test_release();
        do_reset();
        bus.req_i = 6'b000100;
        tick();
        checks++;
        if (bus.grant_o !== 6'b000100) begin
            failures++;
            $display("FAIL rel_own2 got=%b exp=000100", bus.grant_o);
        end
        bus.req_i = 6'b100000;
        tick();
        checks++;
        if (bus.grant_o !== 6'b100000) begin
            failures++;
            $display("FAIL rel_to5 got=%b exp=100000", bus.grant_o);
        end
        bus.req_i = 6'b100100;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (bus.grant_o !== 6'b100000 || bus.hold_o !== 6'b000100) begin
                failures++;
                $display("FAIL rel_keep5 cyc=%0d got=%b hold=%b exp=100000 hold=000100", c, bus.grant_o, bus.hold_o);
            end
        end
        bus.req_i = 6'b000100;
        tick();
        checks++;
        if (bus.grant_o !== 6'b000100) begin
            failures++;
            $display("FAIL rel_back2 got=%b exp=000100", bus.grant_o);
        end
        bus.req_i = 6'b000000;
        tick();
        checks++;
        if (bus.grant_o !== '0 || bus.grant_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL rel_idle got=%b exp=000000", bus.grant_o);
        end
    endtask

    task automatic test_lock_timeout();
        do_reset();
        bus.req_i = 6'b001000;
        tick();
        bus.req_i  = 6'b011001;
        bus.lock_i = 6'b001000;
        for (int c = 1; c < LM; c++) begin
            tick();
            checks++;
            if (bus.grant_o !== 6'b001000 || bus.lock_timeout_o !== 1'b0) begin
                failures++;
                $display("FAIL lock_hold cyc=%0d got=%b to=%b exp=001000 to=0", c, bus.grant_o, bus.lock_timeout_o);
            end
        end
        tick();
        checks++;
        if (bus.grant_o !== 6'b010000 || bus.lock_timeout_o !== 1'b1) begin
            failures++;
            $display("FAIL lock_break got=%b to=%b exp=010000 to=1", bus.grant_o, bus.lock_timeout_o);
        end
        tick();
        checks++;
        if (bus.grant_o !== 6'b010000 || bus.lock_timeout_o !== 1'b0) begin
            failures++;
            $display("FAIL lock_pulse got=%b to=%b exp=010000 to=0", bus.grant_o, bus.lock_timeout_o);
        end
        bus.lock_i = '0;
    endtask

    task automatic test_lock_single();
        do_reset();
        bus.req_i  = 6'b000010;
        bus.lock_i = 6'b000010;
        tick();
        for (int r = 0; r < 2; r++) begin
            for (int c = 1; c < LM; c++) begin
                tick();
                checks++;
                if (bus.grant_o !== 6'b000010 || bus.lock_timeout_o !== 1'b0) begin
                    failures++;
                    $display("FAIL single_hold r=%0d cyc=%0d got=%b to=%b", r, c, bus.grant_o, bus.lock_timeout_o);
                end
            end
            tick();
            checks++;
            if (bus.grant_o !== 6'b000010 || bus.lock_timeout_o !== 1'b1) begin
                failures++;
                $display("FAIL single_regrant r=%0d got=%b to=%b exp=000010 to=1", r, bus.grant_o, bus.lock_timeout_o);
            end
        end
        bus.lock_i = '0;
    endtask

    task automatic test_random();
        logic [M-1:0] r, l, eg;
        int w[M];
        int wmax;
        do_reset();
        r = '0;
        l = '0;
        wmax = 0;
        for (int m = 0; m < M; m++) w[m] = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int m = 0; m < M; m++) begin
                if (!r[m]) begin
                    if ($urandom_range(3) == 0) begin
                        r[m] = 1'b1;
                        l[m] = ($urandom_range(3) == 0);
                    end
                end else if (m == m_owner && $urandom_range(15) == 0) begin
                    r[m] = 1'b0;
                    l[m] = 1'b0;
                end
            end
            bus.req_i  = r;
            bus.lock_i = l;
            tick();
            eg = m_grant_vec();
            checks++;
            if (bus.grant_o !== eg) begin
                failures++;
                $display("FAIL rnd_grant cyc=%0d got=%b exp=%b", cyc, bus.grant_o, eg);
            end
            checks++;
            if (!$onehot0(bus.grant_o) || bus.grant_valid_o !== (m_owner >= 0)) begin
                failures++;
                $display("FAIL rnd_onehot cyc=%0d got=%b valid=%b", cyc, bus.grant_o, bus.grant_valid_o);
            end
            checks++;
            if (bus.hold_o !== (r & ~eg)) begin
                failures++;
                $display("FAIL rnd_hold cyc=%0d got=%b exp=%b", cyc, bus.hold_o, r & ~eg);
            end
            checks++;
            if (bus.lock_timeout_o !== m_to) begin
                failures++;
                $display("FAIL rnd_timeout cyc=%0d got=%b exp=%b", cyc, bus.lock_timeout_o, m_to);
            end
            if (m_owner >= 0) begin
                checks++;
                if (bus.grant_idx_o !== 3'(m_owner)) begin
                    failures++;
                    $display("FAIL rnd_idx cyc=%0d got=%0d exp=%0d", cyc, bus.grant_idx_o, m_owner);
                end
            end
            for (int m = 0; m < M; m++) begin
                if (r[m] && m != m_owner) w[m]++;
                else w[m] = 0;
                if (w[m] > wmax) wmax = w[m];
            end
        end
        checks++;
        if (wmax > (M - 1) * LM + 1) begin
            failures++;
            $display("FAIL rnd_starve got=%0d limit=%0d", wmax, (M - 1) * LM + 1);
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b0;
        bus.req_i  = '0;
        bus.lock_i = '0;
        m_owner    = -1;
        m_last     = M - 1;
        m_ten      = 0;
        m_lk       = 0;
        m_to       = 0;
        @(negedge clk);
        test_reset();
        test_quantum();
        test_release();
        test_lock_timeout();
        test_lock_single();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
